// File: rtl/register_file_16bit_pkg.sv
// rtl/register_file_16bit_pkg.sv - shared constants for the 16-bit register file
package register_file_16bit_pkg;

  localparam int W  = 16;
  localparam int AW = 2;

  localparam logic [AW-1:0] R0 = 2'd0;
  localparam logic [AW-1:0] R1 = 2'd1;
  localparam logic [AW-1:0] R2 = 2'd2;
  localparam logic [AW-1:0] R3 = 2'd3;

  localparam logic [W-1:0] ZERO16 = 16'd0;

endpackage

// File: rtl/register_file_16bit_mux2ne1.sv
// rtl/register_file_16bit_mux2ne1.sv - 16-bit 2:1 mux used for read-port bypass
//   d0 : selected when s = 0 (stored register value)
//   d1 : selected when s = 1 (in-flight write data)
//   s  : select
//   y  : mux output
module mux2ne1_16bit
  import register_file_16bit_pkg::*;
(
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/register_file_16bit.sv
// rtl/register_file_16bit.sv - 2R/1W register file, R0 hardwired to zero, optional bypass
//   Clock     : rising-edge datapath clock
//   Reset     : asynchronous active-low reset
//   RegWrite  : write enable
//   WriteAddr : destination register
//   WriteData : write-back value
//   ReadAddr1 : source register 1 -> ReadData1 (ALU operand A)
//   ReadAddr2 : source register 2 -> ReadData2 (ALU-source mux input 0)
//   DbgAddr   : debug read address -> DbgData (stored value, never bypassed)
//   Written   : bit i set once register i has been written since reset
module register_file_16bit #(
  parameter int W      = register_file_16bit_pkg::W,
  parameter int AW     = register_file_16bit_pkg::AW,
  parameter int NREG   = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            RegWrite,
  input  logic [AW-1:0]   WriteAddr,
  input  logic [W-1:0]    WriteData,
  input  logic [AW-1:0]   ReadAddr1,
  input  logic [AW-1:0]   ReadAddr2,
  output logic [W-1:0]    ReadData1,
  output logic [W-1:0]    ReadData2,
  input  logic [AW-1:0]   DbgAddr,
  output logic [W-1:0]    DbgData,
  output logic [NREG-1:0] Written
);

  import register_file_16bit_pkg::ZERO16;
  import register_file_16bit_pkg::R0;

  // Entry 0 exists only to keep indexing uniform; it is never loaded.
  logic [W-1:0]    regs_q [NREG];
  logic [W-1:0]    regs_d [NREG];
  logic [NREG-1:0] written_q;
  logic [NREG-1:0] written_d;

  logic [W-1:0] stored1;
  logic [W-1:0] stored2;
  logic [W-1:0] stored_dbg;
  logic         hit1;
  logic         hit2;
  logic         sel1;
  logic         sel2;

  // True for an address that maps onto a real, writable register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (a != R0) && (int'(a) < NREG);
  endfunction

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    written_d = written_q;
    for (int i = 1; i < NREG; i++) begin
      if (RegWrite && (int'(WriteAddr) == i)) begin
        regs_d[i]    = WriteData;
        written_d[i] = 1'b1;
      end
    end
    regs_d[0]    = ZERO16;
    written_d[0] = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= ZERO16;
      end
      written_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      written_q <= written_d;
    end
  end

  // Address 0 and unimplemented addresses fall through to zero.
  always_comb begin
    stored1    = ZERO16;
    stored2    = ZERO16;
    stored_dbg = ZERO16;
    for (int i = 1; i < NREG; i++) begin
      if (int'(ReadAddr1) == i) stored1    = regs_q[i];
      if (int'(ReadAddr2) == i) stored2    = regs_q[i];
      if (int'(DbgAddr) == i)   stored_dbg = regs_q[i];
    end
  end

  // Reset gates the bypass so every read output is zero while Reset is low.
  assign hit1 = Reset & RegWrite & (ReadAddr1 == WriteAddr) & addr_live(ReadAddr1);
  assign hit2 = Reset & RegWrite & (ReadAddr2 == WriteAddr) & addr_live(ReadAddr2);
  assign sel1 = BYPASS ? hit1 : 1'b0;
  assign sel2 = BYPASS ? hit2 : 1'b0;

  mux2ne1_16bit u_rd1_mux (
    .d0 (stored1),
    .d1 (WriteData),
    .s  (sel1),
    .y  (ReadData1)
  );

  mux2ne1_16bit u_rd2_mux (
    .d0 (stored2),
    .d1 (WriteData),
    .s  (sel2),
    .y  (ReadData2)
  );

  assign DbgData = stored_dbg;
  assign Written = written_q;

endmodule

// File: tb/tb_register_file_16bit.sv
// tb/tb_register_file_16bit.sv - self-checking bench for register_file_16bit
module tb_register_file_16bit;
  import register_file_16bit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        RegWrite;
  logic [1:0]  WriteAddr;
  logic [15:0] WriteData;
  logic [1:0]  ReadAddr1;
  logic [1:0]  ReadAddr2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [1:0]  DbgAddr;
  logic [15:0] DbgData;
  logic [3:0]  Written;

  logic [15:0] imm;
  logic        alu_src;
  logic [15:0] alu_b;

  int checks = 0;
  int fails  = 0;

  logic [15:0] mem [4];
  logic [3:0]  wmask;

  always #5 Clock = ~Clock;

  register_file_16bit dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr1 (ReadAddr1),
    .ReadAddr2 (ReadAddr2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .DbgAddr   (DbgAddr),
    .DbgData   (DbgData),
    .Written   (Written)
  );

  mux2ne1_16bit u_alu_src_mux (
    .d0 (ReadData2),
    .d1 (imm),
    .s  (alu_src),
    .y  (alu_b)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = 16'd0;
    wmask = 4'd0;
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a, input logic we,
                                             input logic [1:0] wa, input logic [15:0] wd);
    if (a == 2'd0) return 16'd0;
    if (we && a == wa) return wd;
    return mem[a];
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge Clock);
    RegWrite  = 1'b1;
    WriteAddr = a;
    WriteData = d;
    @(posedge Clock);
    #1;
    RegWrite = 1'b0;
    if (a != 2'd0) begin
      mem[a]   = d;
      wmask[a] = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; RegWrite = 1'b0; WriteAddr = R0; WriteData = 16'd0;
    ReadAddr1 = R1; ReadAddr2 = R2; DbgAddr = R3; imm = 16'd0; alu_src = 1'b0;
    model_reset();
    #2;
    checks++; if (ReadData1 !== 16'd0) begin fails++; $display("FAIL reset_rd1: got %h expected 0000", ReadData1); end
    checks++; if (ReadData2 !== 16'd0) begin fails++; $display("FAIL reset_rd2: got %h expected 0000", ReadData2); end
    checks++; if (DbgData !== 16'd0) begin fails++; $display("FAIL reset_dbg: got %h expected 0000", DbgData); end
    checks++; if (Written !== 4'd0) begin fails++; $display("FAIL reset_written: got %b expected 0000", Written); end
    #10;
    Reset = 1'b1;
  endtask

  task automatic test_write_read();
    do_write(R1, 16'd5);
    do_write(R2, 16'd20);
    ReadAddr1 = R1; ReadAddr2 = R2;
    #1;
    checks++; if (ReadData1 !== 16'd5) begin fails++; $display("FAIL wr_rd1: got %0d expected 5", ReadData1); end
    checks++; if (ReadData2 !== 16'd20) begin fails++; $display("FAIL wr_rd2: got %0d expected 20", ReadData2); end
    checks++; if (Written !== 4'b0110) begin fails++; $display("FAIL wr_written: got %b expected 0110", Written); end
  endtask

  task automatic test_r0_write();
    @(negedge Clock);
    RegWrite = 1'b1; WriteAddr = R0; WriteData = 16'hFFFF; ReadAddr1 = R0; DbgAddr = R0;
    #1;
    checks++; if (ReadData1 !== 16'd0) begin fails++; $display("FAIL r0_bypass: got %h expected 0000", ReadData1); end
    @(posedge Clock);
    #1;
    RegWrite = 1'b0;
    #1;
    checks++; if (DbgData !== 16'd0) begin fails++; $display("FAIL r0_dbg: got %h expected 0000", DbgData); end
    checks++; if (Written[0] !== 1'b0) begin fails++; $display("FAIL r0_written: got %b expected 0", Written[0]); end
  endtask

  task automatic test_bypass();
    do_write(R3, 16'd7);
    @(negedge Clock);
    RegWrite = 1'b1; WriteAddr = R3; WriteData = 16'd9;
    ReadAddr1 = R3; ReadAddr2 = R3; DbgAddr = R3;
    #1;
    checks++; if (ReadData1 !== 16'd9) begin fails++; $display("FAIL byp_rd1: got %0d expected 9", ReadData1); end
    checks++; if (ReadData2 !== 16'd9) begin fails++; $display("FAIL byp_rd2: got %0d expected 9", ReadData2); end
    checks++; if (DbgData !== 16'd7) begin fails++; $display("FAIL byp_dbg_pre: got %0d expected 7", DbgData); end
    @(posedge Clock);
    #1;
    RegWrite = 1'b0;
    mem[3] = 16'd9;
    #1;
    checks++; if (DbgData !== 16'd9) begin fails++; $display("FAIL byp_dbg_post: got %0d expected 9", DbgData); end
  endtask

  task automatic test_alu_src_mux();
    @(negedge Clock);
    RegWrite = 1'b0; ReadAddr2 = R2; imm = 16'd5; alu_src = 1'b0;
    #1;
    checks++; if (alu_b !== 16'd20) begin fails++; $display("FAIL alu_src0: got %0d expected 20", alu_b); end
    alu_src = 1'b1;
    #1;
    checks++; if (alu_b !== 16'd5) begin fails++; $display("FAIL alu_src1: got %0d expected 5", alu_b); end
    alu_src = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge Clock);
    #1;
    ReadAddr1 = R1; ReadAddr2 = R2; DbgAddr = R3;
    RegWrite = 1'b1; WriteAddr = R1; WriteData = 16'h1234;
    #1;
    Reset = 1'b0;
    #1;
    checks++; if (ReadData1 !== 16'd0) begin fails++; $display("FAIL arst_rd1: got %h expected 0000", ReadData1); end
    checks++; if (ReadData2 !== 16'd0) begin fails++; $display("FAIL arst_rd2: got %h expected 0000", ReadData2); end
    checks++; if (DbgData !== 16'd0) begin fails++; $display("FAIL arst_dbg: got %h expected 0000", DbgData); end
    checks++; if (Written !== 4'd0) begin fails++; $display("FAIL arst_written: got %b expected 0000", Written); end
    RegWrite = 1'b0;
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    checks++; if (DbgData !== 16'd0) begin fails++; $display("FAIL arst_release: got %h expected 0000", DbgData); end
  endtask

  task automatic test_reset_during_write();
    do_write(R1, 16'd11);
    @(negedge Clock);
    RegWrite = 1'b1; WriteAddr = R1; WriteData = 16'd42; DbgAddr = R1;
    #2;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    RegWrite = 1'b0;
    Reset = 1'b1;
    model_reset();
    #1;
    checks++; if (DbgData !== 16'd0) begin fails++; $display("FAIL rst_edge_r1: got %0d expected 0", DbgData); end
    checks++; if (Written !== 4'd0) begin fails++; $display("FAIL rst_edge_written: got %b expected 0000", Written); end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2, ed;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      RegWrite  = 1'($urandom_range(0, 1));
      WriteAddr = 2'($urandom_range(0, 3));
      WriteData = 16'($urandom);
      ReadAddr1 = 2'($urandom_range(0, 3));
      ReadAddr2 = (n % 4 == 0) ? WriteAddr : 2'($urandom_range(0, 3));
      DbgAddr   = 2'($urandom_range(0, 3));
      #2;
      e1 = model_read(ReadAddr1, RegWrite, WriteAddr, WriteData);
      e2 = model_read(ReadAddr2, RegWrite, WriteAddr, WriteData);
      ed = model_read(DbgAddr, 1'b0, WriteAddr, WriteData);
      checks++; if (ReadData1 !== e1) begin fails++; $display("FAIL rnd_rd1[%0d]: got %h expected %h", n, ReadData1, e1); end
      checks++; if (ReadData2 !== e2) begin fails++; $display("FAIL rnd_rd2[%0d]: got %h expected %h", n, ReadData2, e2); end
      checks++; if (DbgData !== ed) begin fails++; $display("FAIL rnd_dbg[%0d]: got %h expected %h", n, DbgData, ed); end
      checks++; if (Written !== wmask) begin fails++; $display("FAIL rnd_written[%0d]: got %b expected %b", n, Written, wmask); end
      @(posedge Clock);
      #1;
      if (RegWrite && WriteAddr != 2'd0) begin
        mem[WriteAddr]   = WriteData;
        wmask[WriteAddr] = 1'b1;
      end
    end
    RegWrite = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0_write();
    test_bypass();
    test_alu_src_mux();
    test_async_reset();
    test_reset_during_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
